// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: M-extension ALU op codes and the multiply/divide sequencer states.
package rv32_pkg;

    localparam logic [4:0] ALU_OP_MUL    = 5'b01011;
    localparam logic [4:0] ALU_OP_MULH   = 5'b01100;
    localparam logic [4:0] ALU_OP_MULHSU = 5'b01101;
    localparam logic [4:0] ALU_OP_MULHU  = 5'b01110;
    localparam logic [4:0] ALU_OP_DIV    = 5'b01111;
    localparam logic [4:0] ALU_OP_DIVU   = 5'b10000;
    localparam logic [4:0] ALU_OP_REM    = 5'b10001;
    localparam logic [4:0] ALU_OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_e;

    function automatic logic is_m_op(input logic [4:0] op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= ALU_OP_DIV) && (op <= ALU_OP_REMU);
    endfunction

    function automatic logic rs1_signed(input logic [4:0] op);
        return (op == ALU_OP_MULH) || (op == ALU_OP_MULHSU) ||
               (op == ALU_OP_DIV)  || (op == ALU_OP_REM);
    endfunction

    function automatic logic rs2_signed(input logic [4:0] op);
        return (op == ALU_OP_MULH) || (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
// {hi, lo} is the product accumulator (multiply) or {remainder, dividend/quotient} (divide).
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        // Extra top bit acts as the borrow flag of the trial subtraction.
        diff    = {1'b0, shifted} - {2'b00, opnd};
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            if (!diff[XLEN+1]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: stalls the core while a shared radix-2 datapath runs, then
// presents one result for writeback with a single-cycle o_valid pulse.
module muldiv_seq
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [4:0]      i_alu_op,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_main_q, neg_main_d;
    logic            neg_rem_q, neg_rem_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_m;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, fix_result;
    logic            clear;

    assign is_m   = is_m_op(i_alu_op);
    assign sign_a = rs1_signed(i_alu_op) & i_rs1_data[XLEN-1];
    assign sign_b = rs2_signed(i_alu_op) & i_rs2_data[XLEN-1];
    assign abs_a  = sign_a ? -i_rs1_data : i_rs1_data;
    assign abs_b  = sign_b ? -i_rs2_data : i_rs2_data;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div (is_div_op(op_q)),
        .hi     (hi_q),
        .lo     (lo_q),
        .opnd   (opnd_q),
        .hi_next(step_hi),
        .lo_next(step_lo)
    );

    // Sign correction and result selection from the unsigned magnitudes.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_main_q ? -prod : prod;
        quot_fix = neg_main_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -hi_q : hi_q;
        case (op_q)
            ALU_OP_MUL:                            fix_result = prod_fix[XLEN-1:0];
            ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            ALU_OP_DIV, ALU_OP_DIVU:               fix_result = quot_fix;
            ALU_OP_REM, ALU_OP_REMU:               fix_result = rem_fix;
            default:                               fix_result = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        special_d  = special_q;
        result_d   = result_q;
        clear      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start && is_m) begin
                    op_d       = i_alu_op;
                    cnt_d      = '0;
                    hi_d       = '0;
                    neg_main_d = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    special_d  = 1'b0;
                    result_d   = '0;
                    state_d    = CALC;
                    if (is_div_op(i_alu_op)) begin
                        opnd_d = abs_b;
                        lo_d   = abs_a;
                        if (i_rs2_data == '0) begin
                            special_d = 1'b1;
                            state_d   = FIX;
                            result_d  = (i_alu_op == ALU_OP_DIV || i_alu_op == ALU_OP_DIVU) ?
                                        '1 : i_rs1_data;
                        end else if ((i_alu_op == ALU_OP_DIV || i_alu_op == ALU_OP_REM) &&
                                     i_rs1_data == INT_MIN && i_rs2_data == '1) begin
                            special_d = 1'b1;
                            state_d   = FIX;
                            result_d  = (i_alu_op == ALU_OP_DIV) ? INT_MIN : '0;
                        end
                    end else begin
                        opnd_d = abs_a;
                        lo_d   = abs_b;
                    end
                end
            end
            CALC: begin
                if (!i_start) begin
                    clear = 1'b1;
                end else begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIX: begin
                if (!i_start) begin
                    clear = 1'b1;
                end else begin
                    if (!special_q) begin
                        result_d = fix_result;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush/redirect: drop the in-flight op without writeback.
        if (clear) begin
            state_d    = IDLE;
            cnt_d      = '0;
            op_d       = '0;
            opnd_d     = '0;
            hi_d       = '0;
            lo_d       = '0;
            neg_main_d = 1'b0;
            neg_rem_d  = 1'b0;
            special_d  = 1'b0;
            result_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            special_q  <= special_d;
            result_q   <= result_d;
        end
    end

    assign o_stall  = i_start & is_m & (state_q != DONE);
    assign o_valid  = (state_q == DONE);
    assign o_result = o_valid ? result_q : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M vectors, abort, reset and non-M-op cases.
module tb_muldiv_seq;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;
    localparam int LAT_FULL = 34;
    localparam int LAT_SPEC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        stall, valid;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    muldiv_seq #(
        .XLEN(32)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_alu_op  (op),
        .i_rs1_data(a),
        .i_rs2_data(b),
        .o_stall   (stall),
        .o_valid   (valid),
        .o_result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every o_valid pulse must match the oldest expectation, value and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", {31'b0, valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("result_zero_when_idle", result, 32'd0);
            end
        end
    end

    // Waits for the o_valid pulse, checking o_stall on every busy cycle; drops i_start after it.
    task automatic wait_done(input string name);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                done = 1;
                check({name, "_stall_on_valid"}, {31'b0, stall}, 32'd0);
                start = 1'b0;
            end else begin
                check({name, "_stall_busy"}, {31'b0, stall}, 32'd1);
            end
        end
        if (!done) check({name, "_timeout"}, {31'b0, valid}, 32'd1);
    endtask

    task automatic issue(input string name, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_res, input int lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back('{exp_res, cyc + lat, name});
        @(negedge clk);
        check({name, "_stall_issue"}, {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        // Operands are latched at issue; later values must not matter.
        a = $urandom;
        b = $urandom;
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int t;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue("mul_7_m3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_FULL);
        issue("mul_back2back", OP_MUL,    32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,       LAT_FULL);
        issue("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL);
        issue("mulh_m1_m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_FULL);
        issue("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_FULL);
        issue("mulhsu_m1_2",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_FULL);
        issue("divu_100_7",    OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT_FULL);
        issue("remu_100_7",    OP_REMU,   32'd100,      32'd7,        32'd2,        LAT_FULL);
        issue("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT_FULL);
        issue("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT_FULL);
        issue("div_7_m2",      OP_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_FULL);
        issue("rem_7_m2",      OP_REM,    32'd7,        32'hFFFF_FFFE, 32'd1,        LAT_FULL);
        issue("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
        issue("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        LAT_SPEC);
        issue("div_5_0",       OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, LAT_SPEC);
        issue("rem_5_0",       OP_REM,    32'd5,        32'd0,        32'd5,        LAT_SPEC);
        issue("divu_5_0",      OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, LAT_SPEC);
        issue("remu_9_0",      OP_REMU,   32'd9,        32'd0,        32'd9,        LAT_SPEC);

        // Abort: drop i_start at cycle 10 of a mul; no writeback may follow.
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("abort_stall", {31'b0, stall}, 32'd0);
        check("abort_valid", {31'b0, valid}, 32'd0);
        repeat (40) @(negedge clk);
        issue("mul_after_abort", OP_MUL, 32'd11, 32'd13, 32'd143, LAT_FULL);

        // Reset at cycle 20 with i_start held: the op restarts from scratch after reset.
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd6;
        b     = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t   = cyc;
        sb.push_back('{32'd42, t + LAT_FULL, "mul_after_rst"});
        @(negedge clk);
        check("rst_mid_valid", {31'b0, valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        wait_done("mul_after_rst");

        // Non-M ops (addi and the codes just outside the M range) never stall.
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 5'b00000;
        a     = 32'd1;
        b     = 32'd2;
        @(negedge clk);
        check("addi_no_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        op = 5'b01010;
        @(negedge clk);
        check("op_below_m_no_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        op = 5'b10011;
        @(negedge clk);
        check("op_above_m_no_stall", {31'b0, stall}, 32'd0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
